// File: rtl/cmd_executor.sv
// cmd_executor: pops parsed command packets, runs them against the register
// strobe bus and answers each one with a (status, data) byte pair pushed into
// the TX byte FIFO. A read that never returns data is failed after RD_TIMEOUT
// cycles so that a missing register cannot wedge the command path.

package cmd_executor_pkg;

  typedef struct packed {
    logic [1:0] cmd_type;
    logic [7:0] addr;
    logic [7:0] data;
  } cmd_packet_t;

  localparam logic [1:0] OP_NOP     = 2'b00;
  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] OP_READ    = 2'b10;
  localparam logic [1:0] OP_INVALID = 2'b11;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_INVALID = 2'b10;

endpackage

module cmd_executor
  import cmd_executor_pkg::*;
#(
  parameter int unsigned RD_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_fifo_valid,
  input  cmd_packet_t cmd_fifo_rd_data,
  output logic        cmd_fifo_rd_en,
  output logic [7:0]  reg_addr,
  output logic [7:0]  reg_wr_data,
  output logic        reg_wr_en,
  output logic        reg_rd_en,
  input  logic [7:0]  reg_rd_data,
  input  logic        reg_rd_valid,
  input  logic        tx_fifo_full,
  output logic        tx_fifo_wr_en,
  output logic [7:0]  tx_fifo_wr_data,
  output logic        busy,
  output logic [7:0]  err_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    WAIT_RD,
    RESP0,
    RESP1
  } state_t;

  // Counter value seen on the last WAIT_RD cycle that may still accept data.
  localparam logic [7:0] TMO_LAST = 8'(RD_TIMEOUT - 1);

  state_t     state_reg;
  logic [1:0] op_reg;        // opcode of the command in flight
  logic [7:0] data_reg;      // response data byte (write echo / read data / 0)
  logic [1:0] err_code_reg;  // error code reported in the status byte
  logic [7:0] tmo_cnt_reg;   // WAIT_RD cycles without read data

  function automatic logic [7:0] status_byte(input logic [1:0] op, input logic [1:0] err);
    return (err != ERR_NONE) ? {4'hE, err, op} : {4'hA, 2'b00, op};
  endfunction

  // The FIFO is first-word-fall-through, so popping is a pure function of
  // the current state; the packet is captured on the popping edge.
  assign cmd_fifo_rd_en = (state_reg == IDLE) && cmd_fifo_valid;

  // Push whenever a response byte is pending and the TX FIFO has room; the
  // FSM only advances on a cycle where this push actually happens.
  assign tx_fifo_wr_en  = ((state_reg == RESP0) || (state_reg == RESP1)) && !tx_fifo_full;

  // Any state other than IDLE means a command is in flight.
  assign busy = (state_reg != IDLE);

  // Command sequencer: capture, bus access, read wait and response emission.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      op_reg          <= OP_NOP;
      data_reg        <= '0;
      err_code_reg    <= ERR_NONE;
      tmo_cnt_reg     <= '0;
      reg_addr        <= '0;
      reg_wr_data     <= '0;
      reg_wr_en       <= 1'b0;
      reg_rd_en       <= 1'b0;
      tx_fifo_wr_data <= '0;
      err_cnt         <= '0;
    end else begin
      // Bus strobes are single-cycle pulses raised only on the popping edge.
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (cmd_fifo_valid) begin
            op_reg       <= cmd_fifo_rd_data.cmd_type;
            err_code_reg <= ERR_NONE;
            tmo_cnt_reg  <= '0;
            data_reg     <= '0;
            case (cmd_fifo_rd_data.cmd_type)
              OP_WRITE: begin
                // Address/data and strobe become visible together in EXEC.
                reg_addr    <= cmd_fifo_rd_data.addr;
                reg_wr_data <= cmd_fifo_rd_data.data;
                reg_wr_en   <= 1'b1;
                data_reg    <= cmd_fifo_rd_data.data;
                state_reg   <= EXEC;
              end
              OP_READ: begin
                reg_addr    <= cmd_fifo_rd_data.addr;
                reg_wr_data <= cmd_fifo_rd_data.data;
                reg_rd_en   <= 1'b1;
                state_reg   <= EXEC;
              end
              OP_INVALID: begin
                err_code_reg    <= ERR_INVALID;
                tx_fifo_wr_data <= status_byte(OP_INVALID, ERR_INVALID);
                state_reg       <= RESP0;
              end
              default: begin
                tx_fifo_wr_data <= status_byte(OP_NOP, ERR_NONE);
                state_reg       <= RESP0;
              end
            endcase
          end
        end

        EXEC: begin
          if (op_reg == OP_WRITE) begin
            tx_fifo_wr_data <= status_byte(op_reg, ERR_NONE);
            state_reg       <= RESP0;
          end else begin
            tmo_cnt_reg <= '0;
            state_reg   <= WAIT_RD;
          end
        end

        WAIT_RD: begin
          // Data arriving on the last allowed cycle still counts as success.
          if (reg_rd_valid) begin
            data_reg        <= reg_rd_data;
            tx_fifo_wr_data <= status_byte(op_reg, ERR_NONE);
            state_reg       <= RESP0;
          end else if (tmo_cnt_reg == TMO_LAST) begin
            err_code_reg    <= ERR_TIMEOUT;
            tx_fifo_wr_data <= status_byte(op_reg, ERR_TIMEOUT);
            state_reg       <= RESP0;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
          end
        end

        RESP0: begin
          if (!tx_fifo_full) begin
            tx_fifo_wr_data <= data_reg;
            state_reg       <= RESP1;
          end
        end

        RESP1: begin
          if (!tx_fifo_full) begin
            if ((err_code_reg != ERR_NONE) && (err_cnt != 8'hFF)) begin
              err_cnt <= err_cnt + 8'd1;
            end
            state_reg <= IDLE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cmd_executor.md
Name: cmd_executor

Overview:
Consumes parsed command packets from the command FIFO and executes them against the register bank over a simple single-cycle strobe bus. After each command it emits a two-byte response (status, data) into the TX byte FIFO that feeds uart_tx. It sits directly downstream of cmd_parser and the command FIFO.

Parameters:
RD_TIMEOUT, 16, cycles spent in WAIT_RD without reg_rd_valid before a read is declared failed (range 1..255)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
cmd_fifo_valid  input  1  command FIFO non-empty; first-word-fall-through, so rd_data is valid whenever valid=1
cmd_fifo_rd_data  input  cmd_packet_t  {cmd_type[1:0], addr[7:0], data[7:0]}
cmd_fifo_rd_en  output  1  pops the command FIFO
reg_addr  output  8  register bus address
reg_wr_data  output  8  register bus write data
reg_wr_en  output  1  register write strobe
reg_rd_en  output  1  register read strobe
reg_rd_data  input  8  register read data, qualified by reg_rd_valid
reg_rd_valid  input  1  read data valid
tx_fifo_full  input  1  TX byte FIFO full
tx_fifo_wr_en  output  1  TX byte FIFO push
tx_fifo_wr_data  output  8  TX byte
busy  output  1  high in every state except IDLE
err_cnt  output  8  saturating count of error responses

Behaviour:
- Reset is asynchronous on rst_n low. Reset values: state=IDLE; all strobes=0; reg_addr=0; reg_wr_data=0; tx_fifo_wr_data=0; err_cnt=0; internal command, data and timeout registers=0.
- Opcodes (cmd_type):
  - 2'b00 NOP
  - 2'b01 WRITE
  - 2'b10 READ
  - 2'b11 INVALID
- Status byte: {4'hA, 2'b00, cmd_type} on success; {4'hE, err_code[1:0], cmd_type} on error. err_code 2'b01 = read timeout, 2'b10 = invalid opcode.
- Data byte:
  - WRITE: echoes the written data.
  - READ: the captured reg_rd_data.
  - NOP and any error: 8'h00.
- cmd_fifo_rd_en = (state==IDLE) && cmd_fifo_valid. This is combinational and never asserted outside IDLE. The packet is captured on the same edge that pops it.
- FSM states: IDLE, EXEC, WAIT_RD, RESP0, RESP1.
- IDLE:
  - Pop with opcode WRITE or READ goes to EXEC.
  - Pop with NOP or INVALID goes directly to RESP0; no bus access.
- EXEC (exactly 1 cycle): reg_addr and reg_wr_data are driven from the captured packet.
  - WRITE: reg_wr_en=1, then go to RESP0.
  - READ: reg_rd_en=1, then go to WAIT_RD with the timeout counter cleared.
- WAIT_RD:
  - reg_rd_valid is sampled only in this state; pulses arriving in any other state are ignored.
  - If valid, capture reg_rd_data and go to RESP0.
  - Otherwise increment the counter. When the counter reaches RD_TIMEOUT, flag the timeout error and go to RESP0.
  - If valid arrives in the same cycle the limit is reached, valid wins.
- RESP0: drive the status byte. tx_fifo_wr_en = !tx_fifo_full. Advance to RESP1 only on a cycle where the push occurred.
- RESP1: drive the data byte with the same rule, then go to IDLE.
  - err_cnt increments (saturating at 8'hFF) on the RESP1 push of an error response.
- Backpressure: while tx_fifo_full=1 the FSM holds its state with wr_en=0. Bytes are never dropped or duplicated.
- Latency with no backpressure (pop at cycle T):
  - WRITE: reg_wr_en at T+1; bytes at T+2 and T+3; next pop earliest at T+4.
  - READ with valid at T+2: bytes at T+3 and T+4.
  - NOP/INVALID: bytes at T+1 and T+2.
- reg_wr_en and reg_rd_en are never asserted together, and each is high for exactly one cycle per command.
- Reset mid-operation aborts immediately. No strobe or push follows reset release until a new pop occurs. The in-flight command is lost.

Test Plan:
- WRITE {01, addr 8'h10, data 8'h5A} with FIFO not full -> reg_wr_en one cycle at T+1 with addr 10/data 5A; TX bytes A1, 5A at T+2, T+3; err_cnt=0.
- READ {10, 8'h22} with bank returning 8'hC3 one cycle after reg_rd_en -> TX bytes A2, C3; reg_wr_en never asserted.
- READ with reg_rd_valid never asserted (RD_TIMEOUT=16) -> after 16 WAIT_RD cycles, TX bytes E6, 00; err_cnt=1. A late reg_rd_valid pulse in IDLE has no effect.
- INVALID {11, xx, xx} then NOP {00} back-to-back -> TX E B, 00, A0, 00 in order (i.e. bytes EB, 00, A0, 00); no register strobes; err_cnt=1.
- tx_fifo_full held high for 5 cycles during RESP0 of a write, with further commands queued -> status byte held and pushed once on release; no extra pops while stalled.
- rst_n asserted during WAIT_RD, then released with FIFO holding a WRITE -> all outputs return to reset values; the next activity is a normal WRITE sequence; err_cnt=0.
